// File: rtl/wb_uart.sv
// wb_uart: Wishbone classic slave UART (8N1) with a TX FIFO, a single-byte RX
// holding register, sticky status flags and a programmable baud divisor.
//
// rx state | meaning
// RX_IDLE  | line idle, waiting for a synchronized falling edge
// RX_START | counting to the start-bit centre, false start returns to idle
// RX_DATA  | sampling 8 data bits, LSB first, one per bit period
// RX_STOP  | sampling the stop bit, then commit the byte or flag a frame error
module wb_uart #(
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        tx_o,
    input  logic        rx_i
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [15:0] divisor;
    logic        req;
    logic [1:0]  adr_q;
    logic        we_q;
    logic [1:0]  sel_q;
    logic [15:0] wdat_q;
    logic [31:0] rd_mux;
    logic        wr_data, wr_stat, wr_div, rd_data;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        tx_full, tx_empty, push, drop_set;

    logic        tx_busy, tx_bit_end, tx_last, tx_load;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_idx;
    logic [8:0]  tx_sh;

    logic        rx_valid, rx_overrun, rx_frame_err, tx_drop;
    logic [7:0]  rx_data;

    rx_state_t   rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_tick;
    logic [15:0] rx_cnt, half_m1;
    logic [16:0] half_sum;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_sh;
    logic        cnt_half, cnt_bit, rx_shift, rx_done, rx_ferr;

    logic unused;
    assign unused = ^{adr_i[31:4], adr_i[1:0], sel_i[3:2], dat_i[31:16], half_sum[0]};

    // ---------------- bus front end ----------------
    assign req = cyc_i & stb_i & ~ack_o & ~err_o;

    always_comb begin
        rd_mux = 32'h0;
        case (adr_i[3:2])
            2'd0: rd_mux = {24'h0, rx_data};
            2'd1: rd_mux = {25'h0, tx_drop, rx_frame_err, rx_overrun, rx_valid,
                            tx_busy, tx_empty, tx_full};
            2'd2: rd_mux = {16'h0, divisor};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            dat_o  <= 32'h0;
            adr_q  <= 2'd0;
            we_q   <= 1'b0;
            sel_q  <= 2'd0;
            wdat_q <= 16'h0;
        end else if (req) begin
            ack_o  <= (adr_i[3:2] != 2'd3);
            err_o  <= (adr_i[3:2] == 2'd3);
            dat_o  <= we_i ? 32'h0 : rd_mux;
            adr_q  <= adr_i[3:2];
            we_q   <= we_i;
            sel_q  <= sel_i[1:0];
            wdat_q <= dat_i[15:0];
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= 32'h0;
        end
    end

    // All register side effects happen on the edge that closes the ack cycle.
    assign wr_data = ack_o & we_q & (adr_q == 2'd0) & sel_q[0];
    assign wr_stat = ack_o & we_q & (adr_q == 2'd1) & sel_q[0];
    assign wr_div  = ack_o & we_q & (adr_q == 2'd2);
    assign rd_data = ack_o & ~we_q & (adr_q == 2'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            divisor <= DEFAULT_DIVISOR;
        end else if (wr_div) begin
            if (sel_q[0]) divisor[7:0]  <= wdat_q[7:0];
            if (sel_q[1]) divisor[15:8] <= wdat_q[15:8];
        end
    end

    // ---------------- TX FIFO ----------------
    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = wr_data & (~tx_full | tx_load);
    assign drop_set = wr_data & tx_full & ~tx_load;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdat_q[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (tx_load) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX shifter ----------------
    assign tx_bit_end = tx_busy && (tx_cnt == 16'd0);
    assign tx_last    = tx_bit_end && (tx_idx == 4'd9);
    // Reloading on the final stop-bit edge keeps queued frames back to back.
    assign tx_load    = ~tx_empty && (~tx_busy || tx_last);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_busy <= 1'b0;
            tx_o    <= 1'b1;
            tx_cnt  <= 16'd0;
            tx_idx  <= 4'd0;
            tx_sh   <= 9'h1ff;
        end else if (tx_load) begin
            tx_busy <= 1'b1;
            tx_o    <= 1'b0;
            tx_sh   <= {1'b1, mem[rd_ptr[AW-1:0]]};
            tx_idx  <= 4'd0;
            tx_cnt  <= divisor;
        end else if (tx_last) begin
            tx_busy <= 1'b0;
            tx_o    <= 1'b1;
        end else if (tx_bit_end) begin
            tx_o   <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_idx <= tx_idx + 4'd1;
            tx_cnt <= divisor;
        end else if (tx_busy) begin
            tx_cnt <= tx_cnt - 16'd1;
        end
    end

    // ---------------- RX receiver ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall  = rx_prev & ~rx_s2;
    assign rx_tick  = (rx_cnt == 16'd0);
    assign half_sum = {1'b0, divisor} + 17'd1;
    assign half_m1  = (half_sum[16:1] == 16'd0) ? 16'd0 : half_sum[16:1] - 16'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_half = (rx_state == RX_IDLE) & rx_fall;
        cnt_bit  = rx_tick & (((rx_state == RX_START) & ~rx_s2) | (rx_state == RX_DATA));
        rx_shift = rx_tick & (rx_state == RX_DATA);
        rx_done  = rx_tick & (rx_state == RX_STOP) & rx_s2;
        rx_ferr  = rx_tick & (rx_state == RX_STOP) & ~rx_s2;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_cnt  <= 16'd0;
            rx_bits <= 3'd0;
            rx_sh   <= 8'h0;
        end else begin
            if (cnt_half)       rx_cnt <= half_m1;
            else if (cnt_bit)   rx_cnt <= divisor;
            else if (!rx_tick)  rx_cnt <= rx_cnt - 16'd1;
            if (cnt_half)       rx_bits <= 3'd0;
            else if (rx_shift)  rx_bits <= rx_bits + 3'd1;
            if (rx_shift)       rx_sh <= {rx_s2, rx_sh[7:1]};
        end
    end

    // ---------------- status flags ----------------
    // Setting events take priority over both read-clear and write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_data      <= 8'h0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            if (rx_done) rx_data <= rx_sh;

            if (rx_done)      rx_valid <= 1'b1;
            else if (rd_data) rx_valid <= 1'b0;

            if (rx_done && rx_valid && !rd_data) rx_overrun <= 1'b1;
            else if (wr_stat && wdat_q[4])       rx_overrun <= 1'b0;

            if (rx_ferr)                   rx_frame_err <= 1'b1;
            else if (wr_stat && wdat_q[5]) rx_frame_err <= 1'b0;

            if (drop_set)                  tx_drop <= 1'b1;
            else if (wr_stat && wdat_q[6]) tx_drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: a cycle-level bus/TX reference model checked
// every cycle, plus directed register reads with hand-computed values.
module tb_wb_uart;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cyc_i, stb_i, we_i;
    logic [31:0] adr_i, dat_i, dat_o;
    logic [3:0]  sel_i;
    logic        ack_o, err_o, tx_o, rx_i;

    always #5 clk_i = ~clk_i;

    wb_uart #(.FIFO_DEPTH(8), .DEFAULT_DIVISOR(16'd433)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .we_i(we_i), .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .tx_o(tx_o), .rx_i(rx_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    bit          chk_en = 1'b0;
    logic        m_ack, m_err, m_we, m_req;
    logic [1:0]  m_adr;
    logic [3:0]  m_sel;
    logic [31:0] m_dat;
    logic [7:0]  m_q[$];
    logic [7:0]  m_byte;
    bit          m_busy;
    int          m_pos;
    logic [9:0]  m_frame;
    logic [15:0] m_div;
    logic        m_tx;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            m_ack = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_pos = 0;
            m_div = 16'd433; m_q.delete();
        end else begin
            m_tx = m_busy ? m_frame[m_pos / (int'(m_div) + 1)] : 1'b1;
            if (chk_en) begin
                check("ack_o", {31'h0, ack_o}, {31'h0, m_ack});
                check("err_o", {31'h0, err_o}, {31'h0, m_err});
                check("tx_o",  {31'h0, tx_o},  {31'h0, m_tx});
                if (!m_ack) check("dat_o_idle", dat_o, 32'h0);
            end
            // serial line: each frame is 10 bits of DIVISOR+1 clocks
            if (m_busy) begin
                m_pos++;
                if (m_pos == 10 * (int'(m_div) + 1)) m_busy = 1'b0;
            end
            if (!m_busy && m_q.size() > 0) begin
                m_byte  = m_q.pop_front();
                m_frame = {1'b1, m_byte, 1'b0};
                m_busy  = 1'b1;
                m_pos   = 0;
            end
            if (m_ack && m_we && m_adr == 2'd0 && m_sel[0] && m_q.size() < 8)
                m_q.push_back(m_dat[7:0]);
            if (m_ack && m_we && m_adr == 2'd2) begin
                if (m_sel[0]) m_div[7:0]  = m_dat[7:0];
                if (m_sel[1]) m_div[15:8] = m_dat[15:8];
            end
            m_req = cyc_i & stb_i & ~m_ack & ~m_err;
            m_ack = m_req && (adr_i[3:2] != 2'd3);
            m_err = m_req && (adr_i[3:2] == 2'd3);
            if (m_req) begin
                m_adr = adr_i[3:2]; m_we = we_i; m_sel = sel_i; m_dat = dat_i;
            end
        end
    end

    // ---------------- bus / line helpers ----------------
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit exp_err, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = 32'h0;
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; sel_i = s; dat_i = d;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk_i);
            if (ack_o || err_o) begin
                got = 1'b1;
                rd  = dat_o;
                check("response", {30'h0, ack_o, err_o}, exp_err ? 32'h1 : 32'h2);
            end
        end
        if (!got) check("bus_timeout", 32'h0, 32'h1);
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1'b1, a, s, d, 1'b0, rd);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp_v);
        logic [31:0] rd;
        xfer(1'b0, a, 4'hf, 32'h0, 1'b0, rd);
        check(name, rd, exp_v);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int clks);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            rx_i = f[i];
            repeat (clks - 1) @(posedge clk_i);
        end
        @(posedge clk_i); #1;
        rx_i = 1'b1;
        repeat (clks) @(posedge clk_i);
    endtask

    task automatic wait_tx_low(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk_i);
            if (tx_o == 1'b0) seen = 1'b1;
        end
        if (!seen) check("tx_start_timeout", 32'h0, 32'h1);
    endtask

    // ---------------- directed sequence ----------------
    logic [9:0]  a5_line;
    logic [31:0] rdv;

    initial begin
        rst_n_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = 32'h0; sel_i = 4'h0; dat_i = 32'h0; rx_i = 1'b1;
        a5_line = 10'b1101001010;
        repeat (3) @(negedge clk_i);
        check("tx_in_reset", {31'h0, tx_o}, 32'h1);
        #2 rst_n_i = 1'b1;
        chk_en = 1'b1;

        rd_chk("status_after_reset", 32'h4, 32'h0000_0002);
        rd_chk("divisor_reset", 32'h8, 32'd433);

        // single frame, 4 clocks per bit
        wr(32'h8, 4'b0011, 32'h3);
        rd_chk("divisor_3", 32'h8, 32'h3);
        wr(32'h0, 4'b0001, 32'hA5);
        wait_tx_low(10);
        @(negedge clk_i);
        for (int i = 0; i < 10; i++) begin
            check("a5_bit", {31'h0, tx_o}, {31'h0, a5_line[i]});
            if (i < 9) repeat (4) @(negedge clk_i);
        end
        repeat (4) @(negedge clk_i);
        rd_chk("status_tx_done", 32'h4, 32'h0000_0002);

        // fill the FIFO behind a busy shifter, 8 clocks per bit
        wr(32'h8, 4'b0001, 32'h7);
        wr(32'h0, 4'b0001, 32'h00);
        for (int i = 0; i < 9; i++) wr(32'h0, 4'b0001, 32'h10 + i);
        rd_chk("status_full_drop", 32'h4, 32'h0000_0045);
        wr(32'h4, 4'b0001, 32'h40);
        rd_chk("status_drop_clr", 32'h4, 32'h0000_0005);
        repeat (800) @(posedge clk_i);
        rd_chk("status_fifo_drained", 32'h4, 32'h0000_0002);

        // receive path
        send_rx(8'h3C, 1'b1, 8);
        rd_chk("status_rx_valid", 32'h4, 32'h0000_000A);
        rd_chk("rx_data_3c", 32'h0, 32'h0000_003C);
        rd_chk("status_rx_read", 32'h4, 32'h0000_0002);

        send_rx(8'h11, 1'b1, 8);
        send_rx(8'h22, 1'b1, 8);
        send_rx(8'h33, 1'b0, 8);
        rd_chk("status_ovr_ferr", 32'h4, 32'h0000_003A);
        rd_chk("rx_data_22", 32'h0, 32'h0000_0022);
        rd_chk("status_after_rd", 32'h4, 32'h0000_0032);

        @(posedge clk_i); #1 rx_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rx_i = 1'b1;
        repeat (40) @(posedge clk_i);
        rd_chk("status_glitch", 32'h4, 32'h0000_0032);

        wr(32'h4, 4'b0010, 32'h70);
        rd_chk("status_w1c_no_lane", 32'h4, 32'h0000_0032);
        wr(32'h4, 4'b0001, 32'h30);
        rd_chk("status_w1c", 32'h4, 32'h0000_0002);

        // unmapped register
        xfer(1'b1, 32'hC, 4'hf, 32'hFFFF_FFFF, 1'b1, rdv);
        xfer(1'b0, 32'hC, 4'hf, 32'h0, 1'b1, rdv);
        check("err_read_data", rdv, 32'h0);
        rd_chk("status_after_err", 32'h4, 32'h0000_0002);
        rd_chk("divisor_after_err", 32'h8, 32'h7);

        // reset in the middle of a frame with a byte still queued
        wr(32'h0, 4'b0001, 32'h55);
        wr(32'h0, 4'b0001, 32'h66);
        wait_tx_low(10);
        #2 rst_n_i = 1'b0;
        #1 check("tx_async_reset", {31'h0, tx_o}, 32'h1);
        repeat (2) @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        rd_chk("status_after_rst", 32'h4, 32'h0000_0002);
        rd_chk("divisor_after_rst", 32'h8, 32'd433);
        repeat (50) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_uart.md
# wb_uart

Wishbone classic slave UART (8N1) that sits directly downstream of the CPU's Wishbone master port and consumes its load/store bus cycles. It provides a transmit FIFO, a single-byte receive holding register, a status register and a programmable baud divisor. It is the first memory-mapped peripheral behind the CPU bus.

## Interface

Reset is asynchronous and active-low. The block has a single clock.

Parameters:
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of 2, at least 2.
- DEFAULT_DIVISOR, 16'd433: divisor loaded at reset. Bit period = DIVISOR+1 clocks (50 MHz gives 115200 baud).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  32  byte address; only adr_i[3:2] is decoded, the interconnect decodes the upper bits
- sel_i  in  4  byte lane selects
- dat_i  in  32  write data
- dat_o  out  32  read data
- ack_o  out  1  transfer acknowledge
- err_o  out  1  access to an unmapped register
- tx_o  out  1  serial output, idles high
- rx_i  in  1  serial input, asynchronous to clk_i

## Operation

Register map, selected by adr_i[3:2]:
- 0 DATA
  - Write with sel_i[0]=1 pushes dat_i[7:0] into the TX FIFO.
  - If the FIFO is full, the byte is dropped and TX_DROP is set.
  - Read returns {24'b0, rx_data} and clears RX_VALID.
- 1 STATUS, read:
  - bit0 TX_FULL
  - bit1 TX_EMPTY
  - bit2 TX_BUSY (shifter active)
  - bit3 RX_VALID
  - bit4 RX_OVERRUN
  - bit5 RX_FRAME_ERR
  - bit6 TX_DROP
  - remaining bits read 0
- 1 STATUS, write with sel_i[0]=1: bits 4–6 are write-1-to-clear; all other bits are ignored.
- 2 DIVISOR: read/write 16 bits, lanes sel_i[1:0]; upper bits read 0.
- 3: any access asserts err_o instead of ack_o, with no side effects.

Bus rules:
- A write with the required lane deasserted is acknowledged and has no effect.
- Read side effects (clearing RX_VALID) occur only in the cycle that ack_o is high.

TX path:
- The shifter loads the FIFO head when it is idle and the FIFO is non-empty.
- Frame: start (0), 8 data bits LSB-first, stop (1).
- Each bit lasts DIVISOR+1 clocks.
- The shifter is idle when the stop bit completes; a queued byte starts on the next cycle.

RX path:
- rx_i passes through a 2-flop synchronizer.
- States: IDLE → START → DATA → STOP → IDLE.
- IDLE: a synchronized falling edge enters START.
- START: at half-bit ((DIVISOR+1)>>1 clocks) the line is re-sampled. If it is 1, this is a false start and the FSM returns to IDLE.
- DATA: 8 samples, taken every DIVISOR+1 clocks from the start-bit centre.
- STOP: the stop bit is sampled.
  - If it is 0: set RX_FRAME_ERR, discard the byte, return to IDLE.
  - Otherwise: write rx_data and set RX_VALID. If RX_VALID was already set, also set RX_OVERRUN; the new byte overwrites the old one.

## Timing

Reset values:
- ack_o=0, err_o=0, dat_o=0, tx_o=1.
- FIFO empty, both FSMs idle, all flags 0, DIVISOR=DEFAULT_DIVISOR.

Asserting rst_n_i mid-frame:
- Forces tx_o=1 immediately (asynchronously).
- Aborts the RX frame in progress.
- Discards FIFO contents.

Handshake:
- ack_o/err_o are registered: asserted the cycle after cyc_i&stb_i is sampled high, for exactly one cycle.
- They are gated by !ack_o&!err_o, so a master holding stb_i gets at most one response every 2 cycles.
- dat_o is valid in the ack cycle and 0 otherwise.

TX latency:
- A write acked in cycle N with the FIFO empty and the shifter idle drives the start bit on tx_o at N+2.
- TX_EMPTY deasserts at N+1.

RX latency: RX_VALID rises 1 cycle after the stop-bit centre sample.

Simultaneous events:
- DATA read acked in the same cycle the RX FSM sets RX_VALID: the new byte wins, RX_VALID stays 1, RX_OVERRUN is not set.
- Push and pop in the same cycle with the FIFO full: the push is accepted, no drop.
- W1C in the same cycle a flag is being set: set wins.

DIVISOR changes:
- Take effect at the next bit boundary.
- The bit currently in progress keeps its old length.

Pointer width and wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH.

## Test plan

- Reset, then read STATUS → dat_o=32'h0000_0002, ack_o pulses once, tx_o=1.
- DIVISOR=3, write DATA 8'hA5 → tx_o carries 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; TX_BUSY=0 after 40 clocks.
- Write 9 bytes back-to-back with FIFO_DEPTH=8 while the shifter is busy → 8 bytes are transmitted in order, TX_DROP=1; writing STATUS 32'h40 clears it.
- DIVISOR=7, drive 8'h3C on rx_i → RX_VALID=1; read DATA=32'h0000_003C; RX_VALID=0.
- Drive two frames without reading, then a frame with stop=0 → RX_OVERRUN=1, rx_data holds the second byte, RX_FRAME_ERR=1. A 2-clock low glitch on rx_i produces no RX_VALID.
- Access adr_i=32'hC → err_o pulses, ack_o=0, no state change. Assert rst_n_i mid-TX-frame → tx_o=1 without waiting for a clock edge.
